// File: rtl/m_to_n_arb_xbar_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xbar_pkg : width helpers shared by the M-to-N arbitrated crossbar.
// Rev 1.0
// ---------------------------------------------------------------------------
package xbar_pkg;

    // Index width that stays legal (>= 1 bit) even for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_to_n_arb_xbar_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_to_n_arb_xbar_if : request/response bundle of the M-to-N crossbar.
// Rev 1.0
// ---------------------------------------------------------------------------
interface m_to_n_arb_xbar_if
    import xbar_pkg::*;
#(
    parameter int M         = 8,
    parameter int N         = 16,
    parameter int PLD_WIDTH = 32
);
    localparam int SEL_W = idx_w(N);
    localparam int SRC_W = idx_w(M);

    logic [M-1:0]         in_vld;
    logic [M-1:0]         in_rdy;
    logic [PLD_WIDTH-1:0] in_pld  [M-1:0];
    logic [SEL_W-1:0]     select  [M-1:0];
    logic [N-1:0]         out_vld;
    logic [N-1:0]         out_rdy;
    logic [PLD_WIDTH-1:0] out_pld [N-1:0];
    logic [SRC_W-1:0]     out_src [N-1:0];
    logic                 err_sel;

    modport master (
        output in_vld, in_pld, select, out_rdy,
        input  in_rdy, out_vld, out_pld, out_src, err_sel
    );

    modport slave (
        input  in_vld, in_pld, select, out_rdy,
        output in_rdy, out_vld, out_pld, out_src, err_sel
    );
endinterface
`default_nettype wire

// File: rtl/m_to_n_arb_xbar_rr_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb : M-way round-robin arbiter, one-hot grant gated by en.
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arb
    import xbar_pkg::*;
#(
    parameter int M = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [M-1:0]         req,
    input  wire logic                 en,
    output logic      [M-1:0]         gnt,
    output logic      [idx_w(M)-1:0]  gnt_idx
);
    localparam int IDX_W = idx_w(M);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_pos;
    logic             w_found;
    int               w_sum;

    // Scan from the pointer upward, wrapping, and keep the first requester.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_pos   = '0;
        w_sum   = 0;
        for (int k = 0; k < M; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= M) begin
                w_sum = w_sum - M;
            end
            w_pos = IDX_W'(w_sum);
            if (!w_found && req[w_pos]) begin
                w_found = 1'b1;
                w_idx   = w_pos;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (en && w_found) begin
            gnt[w_idx] = 1'b1;
        end
        gnt_idx = w_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && |req) begin
            r_ptr <= (int'(w_idx) == M - 1) ? '0 : w_idx + 1'b1;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule
`default_nettype wire

// File: rtl/m_to_n_arb_xbar.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_to_n_arb_xbar : M inputs to N registered outputs, round-robin per output.
// Rev 1.0
// ---------------------------------------------------------------------------
module m_to_n_arb_xbar
    import xbar_pkg::*;
#(
    parameter int M         = 8,
    parameter int N         = 16,
    parameter int PLD_WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    m_to_n_arb_xbar_if.slave   bus
);
    localparam int SRC_W = idx_w(M);

    typedef struct packed {
        logic                 vld;
        logic [PLD_WIDTH-1:0] pld;
        logic [SRC_W-1:0]     src;
    } slot_t;

    logic [M-1:0] w_oor;
    logic [M-1:0] w_gnt_all [N-1:0];
    logic [M-1:0] w_rdy;
    logic         r_err;

    for (genvar i = 0; i < M; i++) begin : g_in
        assign w_oor[i] = (int'(bus.select[i]) >= N);
    end

    for (genvar j = 0; j < N; j++) begin : g_out
        slot_t            r_slot;
        logic [M-1:0]     w_req;
        logic [M-1:0]     w_gnt;
        logic [SRC_W-1:0] w_gnt_idx;
        logic             w_en;

        for (genvar i = 0; i < M; i++) begin : g_req
            assign w_req[i] = bus.in_vld[i] && (int'(bus.select[i]) == j);
        end

        // A full slot may only take a new entry while it is draining.
        assign w_en = !rst && (!r_slot.vld || bus.out_rdy[j]);

        rr_arb #(.M(M)) u_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (w_req),
            .en      (w_en),
            .gnt     (w_gnt),
            .gnt_idx (w_gnt_idx)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_slot <= '0;
            end else if (|w_gnt) begin
                r_slot.vld <= 1'b1;
                r_slot.pld <= bus.in_pld[w_gnt_idx];
                r_slot.src <= w_gnt_idx;
            end else if (bus.out_rdy[j]) begin
                r_slot.vld <= 1'b0;
            end
        end

        assign w_gnt_all[j]   = w_gnt;
        assign bus.out_vld[j] = r_slot.vld;
        assign bus.out_pld[j] = r_slot.pld;
        assign bus.out_src[j] = r_slot.src;
    end

    // Out-of-range selects are always consumed so they can never block.
    always_comb begin
        w_rdy = w_oor;
        for (int j = 0; j < N; j++) begin
            w_rdy = w_rdy | w_gnt_all[j];
        end
        if (rst) begin
            w_rdy = '0;
        end
    end

    assign bus.in_rdy = w_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|(bus.in_vld & w_oor)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_sel = r_err;

endmodule
`default_nettype wire

// File: tb/tb_m_to_n_arb_xbar.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_m_to_n_arb_xbar : directed + random check of two crossbars (N=4, N=3).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_m_to_n_arb_xbar;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int N3 = 3;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    m_to_n_arb_xbar_if #(.M(M), .N(N),  .PLD_WIDTH(PW)) bus4 ();
    m_to_n_arb_xbar_if #(.M(M), .N(N3), .PLD_WIDTH(PW)) bus3 ();

    m_to_n_arb_xbar #(.M(M), .N(N),  .PLD_WIDTH(PW)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    m_to_n_arb_xbar #(.M(M), .N(N3), .PLD_WIDTH(PW)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Stimulus shared by both instances
    logic [3:0] t_vld;
    logic [3:0] t_ordy;
    logic [1:0] t_sel [4];
    logic [7:0] t_pld [4];

    // Reference: per output one slot plus a rotating priority start point
    logic       m_vld [2][4];
    logic [7:0] m_pld [2][4];
    int         m_src [2][4];
    int         m_ptr [2][4];
    logic       m_err [2];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_err[d] = 1'b0;
            for (int j = 0; j < 4; j++) begin
                m_vld[d][j] = 1'b0;
                m_pld[d][j] = '0;
                m_src[d][j] = 0;
                m_ptr[d][j] = 0;
            end
        end
    endtask

    // One clock: drive, compare against the reference, advance the reference.
    task automatic step(input logic r);
        logic [3:0] o_rdy [2];
        logic [3:0] o_vld [2];
        logic       o_err [2];
        logic [7:0] o_pld [2][4];
        logic [1:0] o_src [2][4];
        logic [3:0] e_rdy;
        logic [3:0] e_vld;
        int         win [4];
        int         nn;
        int         i;

        @(negedge clk);
        rst          = r;
        bus4.in_vld  = t_vld;
        bus3.in_vld  = t_vld;
        bus4.out_rdy = t_ordy;
        bus3.out_rdy = t_ordy[2:0];
        for (int k = 0; k < 4; k++) begin
            bus4.in_pld[k] = t_pld[k];
            bus3.in_pld[k] = t_pld[k];
            bus4.select[k] = t_sel[k];
            bus3.select[k] = t_sel[k];
        end
        #1;
        o_rdy[0] = bus4.in_rdy;
        o_rdy[1] = bus3.in_rdy;
        o_vld[0] = bus4.out_vld;
        o_vld[1] = {1'b0, bus3.out_vld};
        o_err[0] = bus4.err_sel;
        o_err[1] = bus3.err_sel;
        for (int j = 0; j < 4; j++) begin
            o_pld[0][j] = bus4.out_pld[j];
            o_src[0][j] = bus4.out_src[j];
            o_pld[1][j] = (j < 3) ? bus3.out_pld[j] : 8'h0;
            o_src[1][j] = (j < 3) ? bus3.out_src[j] : 2'h0;
        end

        for (int d = 0; d < 2; d++) begin
            nn    = (d == 0) ? N : N3;
            e_rdy = '0;
            e_vld = '0;
            for (int j = 0; j < 4; j++) begin
                win[j] = -1;
                if (j < nn && (!m_vld[d][j] || t_ordy[j])) begin
                    for (int k = 0; k < 4; k++) begin
                        i = (m_ptr[d][j] + k) % 4;
                        if (win[j] < 0 && t_vld[i] && int'(t_sel[i]) == j) win[j] = i;
                    end
                end
                if (win[j] >= 0) e_rdy[win[j]] = 1'b1;
                e_vld[j] = m_vld[d][j];
            end
            for (int k = 0; k < 4; k++) begin
                if (int'(t_sel[k]) >= nn) e_rdy[k] = 1'b1;
            end
            if (r) e_rdy = '0;

            check($sformatf("d%0d in_rdy", d),  64'(o_rdy[d]), 64'(e_rdy));
            check($sformatf("d%0d out_vld", d), 64'(o_vld[d]), 64'(e_vld));
            check($sformatf("d%0d err_sel", d), 64'(o_err[d]), 64'(m_err[d]));
            for (int j = 0; j < nn; j++) begin
                if (m_vld[d][j]) begin
                    check($sformatf("d%0d out_pld%0d", d, j), 64'(o_pld[d][j]), 64'(m_pld[d][j]));
                    check($sformatf("d%0d out_src%0d", d, j), 64'(o_src[d][j]), 64'(m_src[d][j]));
                end
            end

            if (!r) begin
                for (int j = 0; j < nn; j++) begin
                    if (win[j] >= 0) begin
                        m_vld[d][j] = 1'b1;
                        m_pld[d][j] = t_pld[win[j]];
                        m_src[d][j] = win[j];
                        m_ptr[d][j] = (win[j] + 1) % 4;
                    end else if (t_ordy[j]) begin
                        m_vld[d][j] = 1'b0;
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    if (t_vld[k] && int'(t_sel[k]) >= nn) m_err[d] = 1'b1;
                end
            end
        end
        if (r) model_clear();
        @(posedge clk);
    endtask

    task automatic idle();
        t_vld  = '0;
        t_ordy = 4'hF;
        step(1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        t_vld  = '0;
        t_ordy = 4'hF;
        for (int k = 0; k < 4; k++) begin
            t_sel[k] = '0;
            t_pld[k] = '0;
        end
        bus4.in_vld = '0; bus3.in_vld = '0;
        bus4.out_rdy = '1; bus3.out_rdy = '1;
        for (int k = 0; k < 4; k++) begin
            bus4.in_pld[k] = '0; bus3.in_pld[k] = '0;
            bus4.select[k] = '0; bus3.select[k] = '0;
        end
        repeat (2) @(posedge clk);
        model_clear();
        step(1'b1);
        #1;
        check("rst out_pld0", 64'(bus4.out_pld[0]), 64'h0);
        check("rst out_src0", 64'(bus4.out_src[0]), 64'h0);

        // Four-way conflict on output 1
        t_vld = 4'hF;
        for (int k = 0; k < 4; k++) begin
            t_sel[k] = 2'd1;
            t_pld[k] = 8'(8'h10 * k + 1);
        end
        for (int n = 0; n < 5; n++) begin
            step(1'b0);
            #1;
            check($sformatf("rr src step%0d", n), 64'(bus4.out_src[1]), 64'(n % 4));
        end
        idle();

        // Single path
        t_vld = 4'b0001; t_sel[0] = 2'd2; t_pld[0] = 8'hA5;
        step(1'b0);
        #1;
        check("single vld", 64'(bus4.out_vld[2]), 64'h1);
        check("single pld", 64'(bus4.out_pld[2]), 64'hA5);
        check("single src", 64'(bus4.out_src[2]), 64'h0);
        idle();

        // Backpressure on output 3, then drain and refill together
        t_ordy = 4'b0111;
        t_vld = 4'b0001; t_sel[0] = 2'd3; t_pld[0] = 8'h11;
        step(1'b0);
        t_vld = 4'b0010; t_sel[1] = 2'd3; t_pld[1] = 8'h22;
        for (int n = 0; n < 5; n++) begin
            step(1'b0);
            #1;
            check("bp hold pld", 64'(bus4.out_pld[3]), 64'h11);
            check("bp in_rdy1", 64'(bus4.in_rdy[1]), 64'h0);
        end
        t_ordy = 4'hF;
        step(1'b0);
        #1;
        check("bp refill vld", 64'(bus4.out_vld[3]), 64'h1);
        check("bp refill pld", 64'(bus4.out_pld[3]), 64'h22);
        idle();

        // Parallel: in_k -> 3-k
        t_vld = 4'hF;
        for (int k = 0; k < 4; k++) begin
            t_sel[k] = 2'(3 - k);
            t_pld[k] = 8'(8'hC0 + k);
        end
        step(1'b0);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("par pld%0d", 3 - k), 64'(bus4.out_pld[3 - k]), 64'(8'hC0 + k));
        end

        // Move output 0 pointer away from 0, then reset with slots full
        t_vld = 4'b0001; t_sel[0] = 2'd0; t_pld[0] = 8'h5A;
        step(1'b0);
        t_vld = '0; t_ordy = '0;
        step(1'b0);
        step(1'b1);
        #1;
        check("rst out_vld", 64'(bus4.out_vld), 64'h0);
        t_vld = 4'hF; t_ordy = 4'hF;
        for (int k = 0; k < 4; k++) t_sel[k] = 2'd0;
        step(1'b0);
        #1;
        check("post-rst src0", 64'(bus4.out_src[0]), 64'h0);
        idle();

        // Out-of-range select on the N=3 instance
        t_vld = 4'b0100; t_sel[2] = 2'd3; t_pld[2] = 8'h77;
        step(1'b0);
        #1;
        check("oor out_vld", 64'(bus3.out_vld), 64'h0);
        check("oor err_sel", 64'(bus3.err_sel), 64'h1);
        repeat (3) idle();
        #1;
        check("oor sticky", 64'(bus3.err_sel), 64'h1);
        step(1'b1);
        #1;
        check("oor cleared", 64'(bus3.err_sel), 64'h0);

        // Random traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            t_vld  = 4'($urandom);
            t_ordy = 4'($urandom) | 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                t_sel[k] = 2'($urandom_range(0, 3));
                t_pld[k] = 8'($urandom);
            end
            step($urandom_range(0, 63) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
